if_fetch_unit: RTL and testbench

- Instruction-fetch producer stage that writes the IF/ID pipeline register.
- Owns the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents {instruction, PC+4} with a valid flag.
- Honours downstream stall and branch/jump redirect, including discarding stale in-flight responses.

---
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests, small return FIFO, stall and redirect handling.
// Optional same-cycle data bypass when FETCH_BYPASS_EN is defined.
module if_fetch_unit #(
    parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
    parameter int unsigned  BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] adder1
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_buf_inst [BUF_DEPTH];
    logic [31:0]     r_buf_pc   [BUF_DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_head_valid;
    logic            w_fetch_ack;
    logic [31:0]     w_ack_pc;
    logic            w_bypass;
    logic            w_bypass_taken;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_next;
    logic            w_credit;
    logic [31:0]     w_redirect_pc;
    logic            w_unused_pc_lsb;

    assign w_head_valid    = (r_count != '0);
    assign w_fetch_ack     = imem_ack & (r_state == S_REQ);
    assign w_ack_pc        = imem_addr + 32'd4;
    assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsb = ^redirect_pc[1:0];

`ifdef FETCH_BYPASS_EN
    // Empty FIFO: the returning word goes straight to the outputs; only pushed if not consumed.
    assign w_bypass       = ~w_head_valid & w_fetch_ack & ~redirect;
    assign w_bypass_taken = w_bypass & ~stall;
`else
    assign w_bypass       = 1'b0;
    assign w_bypass_taken = 1'b0;
`endif

    assign w_push       = w_fetch_ack & ~redirect & ~w_bypass_taken;
    assign w_pop        = w_head_valid & ~stall;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_credit     = (w_count_next < CW'(BUF_DEPTH));

    assign inst_valid  = w_head_valid | w_bypass;
    assign instruction = w_head_valid ? r_buf_inst[r_rd_ptr] : (w_bypass ? imem_rdata : 32'd0);
    assign adder1      = w_head_valid ? r_buf_pc[r_rd_ptr]   : (w_bypass ? w_ack_pc   : 32'd0);

    // Request FSM: owns fetch PC and the registered imem request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            if ((r_state == S_IDLE) || imem_ack) begin
                r_state  <= S_IDLE;
                imem_req <= 1'b0;
            end else begin
                r_state  <= S_DISCARD;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_credit) begin
                        r_state   <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        if (w_credit) begin
                            imem_addr <= r_fetch_pc + 32'd4;
                        end else begin
                            r_state  <= S_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        r_state  <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Entry storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= imem_rdata;
            r_buf_pc[r_wr_ptr]   <= w_ack_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit (default build, BUF_DEPTH=2, RESET_PC=0) with an in-line memory responder.
module tb_if_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] adder1;

    int n_vec;
    int n_fail;
    int ack_cnt;
    int mem_wait;
    int mem_lat;
    bit mem_auto;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .adder1      (adder1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: ack after mem_lat wait cycles, data = ~address.
    task automatic mem_update();
        if (mem_auto) begin
            if (!imem_req) begin
                imem_ack = 1'b0;
                mem_wait = 0;
            end else begin
                if (imem_ack) mem_wait = 0;
                if (mem_wait >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = ~imem_addr;
                end else begin
                    imem_ack = 1'b0;
                    mem_wait++;
                end
            end
        end
    endtask

    task automatic tick();
        if (imem_req && imem_ack) ack_cnt++;
        @(posedge clock);
        #1;
        mem_update();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        imem_ack  = 1'b0;
        mem_wait  = 0;
        stall     = 1'b0;
        redirect  = 1'b0;
        tick();
        tick();
        ack_cnt = 0;
        reset   = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_fail = 0; ack_cnt = 0; mem_wait = 0; mem_lat = 0; mem_auto = 1'b1;
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        #12;
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_addr",  imem_addr,           32'h0000_0000);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst",  instruction,         32'd0);
        chk("rst_adder", adder1,              32'd0);

        // Zero-wait stream
        do_reset();
        tick();
        chk("zw_req1",   {31'd0, imem_req},   32'd1);
        chk("zw_addr0",  imem_addr,           32'h0);
        chk("zw_val0",   {31'd0, inst_valid}, 32'd0);
        tick();
        chk("zw_addr4",  imem_addr,           32'h4);
        chk("zw_inst0",  instruction,         32'hFFFF_FFFF);
        chk("zw_add4",   adder1,              32'h4);
        tick();
        chk("zw_addr8",  imem_addr,           32'h8);
        chk("zw_inst4",  instruction,         32'hFFFF_FFFB);
        chk("zw_add8",   adder1,              32'h8);
        tick();
        chk("zw_addrC",  imem_addr,           32'hC);
        chk("zw_val3",   {31'd0, inst_valid}, 32'd1);
        chk("zw_inst8",  instruction,         32'hFFFF_FFF7);
        chk("zw_addC",   adder1,              32'hC);

        // Stall from first valid cycle: credit runs out after two acks
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        tick();
        chk("st_req0",   {31'd0, imem_req},   32'd0);
        chk("st_head",   instruction,         32'hFFFF_FFFF);
        chk("st_add4",   adder1,              32'h4);
        tick();
        tick();
        chk("st_req0b",  {31'd0, imem_req},   32'd0);
        chk("st_valid",  {31'd0, inst_valid}, 32'd1);
        chk("st_headb",  instruction,         32'hFFFF_FFFF);
        chk("st_acks",   32'(ack_cnt),        32'd2);
        stall = 1'b0;
        tick();
        chk("st_rel_req",  {31'd0, imem_req}, 32'd1);
        chk("st_rel_addr", imem_addr,         32'h8);
        chk("st_rel_inst", instruction,       32'hFFFF_FFFB);
        chk("st_rel_add",  adder1,            32'h8);
        tick();
        chk("st_w8_inst",  instruction,       32'hFFFF_FFF7);
        chk("st_w8_add",   adder1,            32'hC);

        // Redirect during a 3-wait-cycle request: stale ack discarded
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        chk("rd_hold_addr", imem_addr, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("rd_disc_req",  {31'd0, imem_req},   32'd1);
        chk("rd_disc_addr", imem_addr,           32'h0);
        chk("rd_disc_val",  {31'd0, inst_valid}, 32'd0);
        tick();
        tick();
        chk("rd_idle_req",  {31'd0, imem_req},   32'd0);
        chk("rd_stale_val", {31'd0, inst_valid}, 32'd0);
        chk("rd_stale_ins", instruction,         32'd0);
        tick();
        chk("rd_new_req",   {31'd0, imem_req},   32'd1);
        chk("rd_new_addr",  imem_addr,           32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_wait_val", {31'd0, inst_valid}, 32'd0);
        end
        tick();
        chk("rd_first_val", {31'd0, inst_valid}, 32'd1);
        chk("rd_first_add", adder1,              32'h0000_0104);
        chk("rd_first_ins", instruction,         32'hFFFF_FEFF);

        // Redirect coincident with ack: no DISCARD cycle
        mem_lat = 0;
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        chk("ra_req0",   {31'd0, imem_req},   32'd0);
        chk("ra_val0",   {31'd0, inst_valid}, 32'd0);
        tick();
        chk("ra_req1",   {31'd0, imem_req},   32'd1);
        chk("ra_addr",   imem_addr,           32'h0000_0040);
        tick();
        chk("ra_inst",   instruction,         32'hFFFF_FFBF);
        chk("ra_add",    adder1,              32'h0000_0044);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        chk("wr_addr",   imem_addr,           32'hFFFF_FFFC);
        tick();
        chk("wr_val",    {31'd0, inst_valid}, 32'd1);
        chk("wr_add",    adder1,              32'h0000_0000);
        chk("wr_inst",   instruction,         32'h0000_0003);
        chk("wr_next",   imem_addr,           32'h0000_0000);

        // Asynchronous reset mid-request, then stray ack while idle
        chk("ar_pre_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("ar_req",    {31'd0, imem_req},   32'd0);
        chk("ar_addr",   imem_addr,           32'h0);
        chk("ar_val",    {31'd0, inst_valid}, 32'd0);
        chk("ar_inst",   instruction,         32'd0);
        chk("ar_add",    adder1,              32'd0);
        mem_auto   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("ar_hold_val", {31'd0, inst_valid}, 32'd0);
        reset = 1'b1;
        tick();
        chk("ar_rel_req",  {31'd0, imem_req},   32'd1);
        chk("ar_rel_addr", imem_addr,           32'h0);
        chk("ar_rel_val",  {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b0;
        mem_auto = 1'b1;
        mem_wait = 0;
        mem_update();
        tick();
        chk("ar_inst0",  instruction,         32'hFFFF_FFFF);
        chk("ar_add4",   adder1,              32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
